cmd_seq_checker: RTL and testbench
==================================

// Module: cmd_seq_checker
// PURPOSE
//  Self-checking command sequencer. Drives a list of NUM_CMDS 16-bit commands into RemoteComm.
//  Each step: send the command, wait for cmd_sent, then wait for the response byte and an optional
//  per-step event (e.g. NEMO_setup, cal_done). A timeout applies to every wait.
//  Reports pass, or the failing step and a failure code. Used in bench and FPGA bring-up of KnightsTour.
// PARAMETERS
//  NUM_CMDS  4        number of sequence steps (>=1)
//  TIMEOUT   1000000  clk cycles allowed per wait phase (>=2)
//  ACK       8'hA5    expected positive response byte
// PORTS
//  clk        in   1            system clock
//  rst_n      in   1            asynchronous reset, active low
//  start      in   1            begin sequence; sampled only in IDLE or DONE
//  abort      in   1            return to IDLE; pass/fail left cleared
//  cmd_list   in   NUM_CMDS*16  step i command = cmd_list[16*i+:16]; step 0 sent first
//  wait_evt   in   NUM_CMDS     bit i=1: step i also requires a rising edge of evt[i]
//  evt        in   NUM_CMDS     per-step event inputs (synchronous to clk)
//  cmd        out  16           command to RemoteComm
//  send_cmd   out  1            one-cycle send pulse to RemoteComm
//  cmd_sent   in   1            RemoteComm finished transmitting
//  resp_rdy   in   1            response byte valid (one-cycle pulse)
//  resp       in   8            response byte
//  busy       out  1            sequence in progress
//  pass       out  1            all steps OK; held until start, abort or reset
//  fail       out  1            sequence failed; held until start, abort or reset
//  fail_step  out  max(1,$clog2(NUM_CMDS))  index of the failing step
//  fail_code  out  2            00 NACK, 01 cmd_sent timeout, 10 response/event timeout, 11 reserved
// BEHAVIOUR
//  Reset values: cmd=0, send_cmd=0, busy=0, pass=0, fail=0, fail_step=0, fail_code=0, state=IDLE.
//  States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE.
//  IDLE/DONE + start:
//    - clear pass, fail, fail_step, fail_code; step=0; go to SEND.
//    - busy=1 from the next cycle.
//  SEND:
//    - cmd <= cmd_list[step]; send_cmd=1 for exactly this one cycle.
//    - clear timer, evt_seen and resp_ok; go to WAIT_SENT.
//    - First send_cmd occurs 1 cycle after start is sampled.
//  WAIT_SENT:
//    - cmd_sent=1: clear timer; go to WAIT_RESP.
//    - timer reaches TIMEOUT: fail_code=01; go to DONE.
//  WAIT_RESP:
//    - resp_rdy & resp==ACK: set resp_ok.
//    - resp_rdy & resp!=ACK: fail_code=00; go to DONE.
//    - Step complete when resp_ok & (evt_seen | ~wait_evt[step]).
//    - On completion: if step==NUM_CMDS-1, pass=1 and go to DONE; else step+1 and go to SEND.
//    - timer reaches TIMEOUT before completion: fail_code=10; go to DONE.
//  Timer: width $clog2(TIMEOUT+1); counts cycles spent in the current wait state.
//    - Timeout fires in the cycle the count equals TIMEOUT-1 with no completion.
//  Event edge detect:
//    - evt_d registered each cycle; rise = evt[step] & ~evt_d[step].
//    - evt_seen is set by a rise in SEND, WAIT_SENT or WAIT_RESP, so an event may precede the ACK.
//  On failure: fail=1, fail_step=step, busy=0, state DONE. pass and fail are never both 1.
//  Simultaneous events:
//    - completion condition and timeout in the same cycle: completion wins.
//    - evt rise and a good resp_rdy in the same cycle: both count; the step completes that cycle.
//    - abort and start in the same cycle: abort wins.
//  resp_rdy in SEND or WAIT_SENT is ignored; only WAIT_RESP samples resp.
//  start while busy is ignored. cmd holds its last value in DONE/IDLE.
//  Async reset mid-sequence: all outputs drop to reset values at once; send_cmd never glitches high.
// TESTING (NUM_CMDS=2, TIMEOUT=200, ACK=A5, cmd_list={16'h4001,16'h2000}, wait_evt=2'b10)
//  1 start; cmd_sent after 20 cycles, resp A5; evt[1] rise 30 cycles before step 1 resp A5
//    -> two send_cmd pulses (cmd=2000, then 4001); pass=1; busy=0.
//  2 step 0 resp 8'h5A -> fail=1, fail_step=0, fail_code=00; no second send_cmd.
//  3 step 0 cmd_sent never asserts -> fail_code=01 exactly 200 cycles after WAIT_SENT entry.
//  4 step 1 resp A5 but evt[1] held low -> fail_step=1, fail_code=10; on resp while evt already
//    high with no new edge -> same failure.
//  5 evt[1] rise coincident with resp A5 on timer cycle 199 -> pass=1 (completion beats timeout).
//  6 rst_n low during WAIT_RESP, then start -> outputs zero immediately; fresh run from step 0
//    passes; start during busy and abort mid-run exercised -> ignored / IDLE with pass=fail=0.

Source files
------------

// File: rtl/cmd_seq_checker_if.sv
// Command/response link between the sequencer and RemoteComm.
// The master side issues commands; the slave side answers.
interface cmd_seq_checker_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output send_cmd,
    input  cmd_sent,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  send_cmd,
    output cmd_sent,
    output resp_rdy,
    output resp
  );
endinterface

// File: rtl/cmd_seq_checker.sv
// Self-checking command sequencer for RemoteComm bring-up.
// Sends each command, awaits cmd_sent, ACK and optional event.
module cmd_seq_checker #(
  parameter int          NUM_CMDS = 4,
  parameter int          TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK      = 8'hA5,
  localparam int SW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CMDS*16-1:0]  cmd_list,
  input  logic [NUM_CMDS-1:0]     wait_evt,
  input  logic [NUM_CMDS-1:0]     evt,
  cmd_seq_checker_if.master       rc,
  output logic                    busy,
  output logic                    pass,
  output logic                    fail,
  output logic [SW-1:0]           fail_step,
  output logic [1:0]              fail_code
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       step_q, step_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_CMDS-1:0] evt_d_q;
  logic                seen_q, seen_d;
  logic                rok_q, rok_d;
  logic [15:0]         cmd_q, cmd_d;
  logic                send_q, send_d;
  logic                busy_q, busy_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [SW-1:0]       fstep_q, fstep_d;
  logic [1:0]          fcode_q, fcode_d;

  logic          rise;
  logic          ack_now;
  logic          nack_now;
  logic          tmo;
  logic          ok_now;
  logic          seen_now;
  logic          cmpl;
  logic          last;
  logic [SW-1:0] nstep;

  assign rise     = evt[step_q] & ~evt_d_q[step_q];
  assign ack_now  = rc.resp_rdy & (rc.resp == ACK);
  assign nack_now = rc.resp_rdy & (rc.resp != ACK);
  assign tmo      = (timer_q == TW'(TIMEOUT - 1));
  assign ok_now   = rok_q | ack_now;
  assign seen_now = seen_q | rise;
  assign cmpl     = ok_now & (seen_now | ~wait_evt[step_q]);
  assign last     = (step_q == SW'(NUM_CMDS - 1));
  assign nstep    = step_q + 1'b1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    timer_d = timer_q;
    seen_d  = seen_q;
    rok_d   = rok_q;
    cmd_d   = cmd_q;
    send_d  = 1'b0;
    busy_d  = busy_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fstep_d = fstep_q;
    fcode_d = fcode_q;
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      fstep_d = '0;
      fcode_d = 2'b00;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = SEND;
            step_d  = '0;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            fstep_d = '0;
            fcode_d = 2'b00;
            send_d  = 1'b1;
            cmd_d   = cmd_list[15:0];
          end
        end
        SEND: begin
          timer_d = '0;
          seen_d  = rise;
          rok_d   = 1'b0;
          state_d = WAIT_SENT;
        end
        WAIT_SENT: begin
          seen_d = seen_now;
          if (rc.cmd_sent) begin
            timer_d = '0;
            state_d = WAIT_RESP;
          end else if (tmo) begin
            state_d = DONE;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            fstep_d = step_q;
            fcode_d = 2'b01;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_RESP: begin
          seen_d = seen_now;
          rok_d  = ok_now;
          if (nack_now) begin
            state_d = DONE;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            fstep_d = step_q;
            fcode_d = 2'b00;
          end else if (cmpl) begin
            if (last) begin
              state_d = DONE;
              busy_d  = 1'b0;
              pass_d  = 1'b1;
            end else begin
              // cmd and pulse are loaded together on SEND entry
              state_d = SEND;
              step_d  = nstep;
              send_d  = 1'b1;
              cmd_d   = cmd_list[16*nstep +: 16];
            end
          end else if (tmo) begin
            state_d = DONE;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            fstep_d = step_q;
            fcode_d = 2'b10;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      timer_q <= '0;
      evt_d_q <= '0;
      seen_q  <= 1'b0;
      rok_q   <= 1'b0;
      cmd_q   <= '0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fstep_q <= '0;
      fcode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      evt_d_q <= evt;
      seen_q  <= seen_d;
      rok_q   <= rok_d;
      cmd_q   <= cmd_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fstep_q <= fstep_d;
      fcode_q <= fcode_d;
    end
  end

  assign rc.cmd      = cmd_q;
  assign rc.send_cmd = send_q;
  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_step   = fstep_q;
  assign fail_code   = fcode_q;

endmodule

// File: tb/tb_cmd_seq_checker.sv
// Directed bench for cmd_seq_checker: pass run, NACK, both
// timeouts, completion-vs-timeout, async reset, busy start, abort.
module tb_cmd_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cmd_list;
  logic [1:0]  wait_evt;
  logic [1:0]  evt;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [0:0]  fail_step;
  logic [1:0]  fail_code;

  int total = 0;
  int bad   = 0;
  int nsend = 0;
  int n0;

  cmd_seq_checker_if rc ();

  cmd_seq_checker #(
    .NUM_CMDS (2),
    .TIMEOUT  (200),
    .ACK      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cmd_list  (cmd_list),
    .wait_evt  (wait_evt),
    .evt       (evt),
    .rc        (rc),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .fail_step (fail_step),
    .fail_code (fail_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rc.send_cmd === 1'b1) nsend++;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_sent;
    rc.cmd_sent = 1'b1;
    tick();
    rc.cmd_sent = 1'b0;
  endtask

  task automatic pulse_resp(input logic [7:0] b);
    rc.resp_rdy = 1'b1;
    rc.resp     = b;
    tick();
    rc.resp_rdy = 1'b0;
    rc.resp     = 8'h00;
  endtask

  task automatic run_pass(input string p);
    int base;
    base  = nsend;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({p, "_send0"}, rc.send_cmd, 1);
    chk({p, "_cmd0"}, rc.cmd, 32'h2000);
    chk({p, "_busy"}, busy, 1);
    chk({p, "_pclr"}, pass, 0);
    tick();
    chk({p, "_send0_off"}, rc.send_cmd, 0);
    repeat (19) tick();
    pulse_sent();
    pulse_resp(8'hA5);
    chk({p, "_send1"}, rc.send_cmd, 1);
    chk({p, "_cmd1"}, rc.cmd, 32'h4001);
    evt = 2'b10;
    tick();
    repeat (4) tick();
    pulse_sent();
    repeat (24) tick();
    pulse_resp(8'hA5);
    chk({p, "_pass"}, pass, 1);
    chk({p, "_nofail"}, fail, 0);
    chk({p, "_idle"}, busy, 0);
    chk({p, "_nsend"}, nsend - base, 2);
    evt = 2'b00;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    cmd_list    = {16'h4001, 16'h2000};
    wait_evt    = 2'b10;
    evt         = 2'b00;
    rc.cmd_sent = 1'b0;
    rc.resp_rdy = 1'b0;
    rc.resp     = 8'h00;
    #2;
    chk("rst_cmd", rc.cmd, 0);
    chk("rst_send", rc.send_cmd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fstep", fail_step, 0);
    chk("rst_fcode", fail_code, 0);
    #20 rst_n = 1'b1;
    tick();

    // 1: full pass run, event rises before the step-1 ACK
    run_pass("t1");

    // 2: NACK on step 0
    n0    = nsend;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_pass_clr", pass, 0);
    tick();
    pulse_sent();
    pulse_resp(8'h5A);
    chk("t2_fail", fail, 1);
    chk("t2_fstep", fail_step, 0);
    chk("t2_fcode", fail_code, 2'b00);
    chk("t2_busy", busy, 0);
    chk("t2_pass", pass, 0);
    repeat (5) tick();
    chk("t2_nsend", nsend - n0, 1);

    // 3: cmd_sent never arrives
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_fail_clr", fail, 0);
    tick();
    repeat (199) tick();
    chk("t3_early", fail, 0);
    tick();
    chk("t3_fail", fail, 1);
    chk("t3_fcode", fail_code, 2'b01);
    chk("t3_fstep", fail_step, 0);

    // 4a: step 1 ACKed but evt[1] stays low
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pulse_sent();
    pulse_resp(8'hA5);
    tick();
    pulse_sent();
    pulse_resp(8'hA5);
    repeat (198) tick();
    chk("t4a_early", fail, 0);
    tick();
    chk("t4a_fail", fail, 1);
    chk("t4a_fstep", fail_step, 1);
    chk("t4a_fcode", fail_code, 2'b10);

    // 4b: evt[1] already high, no new edge
    evt   = 2'b10;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pulse_sent();
    pulse_resp(8'hA5);
    tick();
    pulse_sent();
    pulse_resp(8'hA5);
    for (int i = 0; i < 300 && fail !== 1'b1; i++) tick();
    chk("t4b_fail", fail, 1);
    chk("t4b_fstep", fail_step, 1);
    chk("t4b_fcode", fail_code, 2'b10);
    evt = 2'b00;
    tick();

    // 5: event rise and ACK on the last timer cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pulse_sent();
    pulse_resp(8'hA5);
    tick();
    pulse_sent();
    repeat (199) tick();
    chk("t5_pending", pass | fail, 0);
    evt         = 2'b10;
    rc.resp_rdy = 1'b1;
    rc.resp     = 8'hA5;
    tick();
    rc.resp_rdy = 1'b0;
    chk("t5_pass", pass, 1);
    chk("t5_nofail", fail, 0);
    evt = 2'b00;
    tick();

    // 6: async reset mid-WAIT_RESP, then fresh run
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pulse_sent();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cmd", rc.cmd, 0);
    chk("t6_rst_send", rc.send_cmd, 0);
    chk("t6_rst_pf", {pass, fail}, 0);
    #20 rst_n = 1'b1;
    tick();
    run_pass("t6");

    // start while busy and stray resp in WAIT_SENT are ignored
    n0    = nsend;
    start = 1'b1;
    tick();
    start       = 1'b0;
    tick();
    start       = 1'b1;
    rc.resp_rdy = 1'b1;
    rc.resp     = 8'h5A;
    tick();
    start       = 1'b0;
    rc.resp_rdy = 1'b0;
    chk("t6_busy_start_send", rc.send_cmd, 0);
    chk("t6_busy_hold", busy, 1);
    chk("t6_stray_resp", fail, 0);
    tick();
    chk("t6_busy_nsend", nsend - n0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_pf", {pass, fail}, 0);

    // abort in DONE clears pass; abort beats start
    run_pass("t6b");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_pass", pass, 0);
    n0    = nsend;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_ab_busy", busy, 0);
    chk("t6_ab_send", rc.send_cmd, 0);
    repeat (3) tick();
    chk("t6_ab_nsend", nsend - n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
